twi_reg_writer: RTL

- TWI (I2C) master that performs single-register writes to the on-board video encoder, e.g. the DVI transmitter at 7-bit address 0x76.
- Sits between the video-control GPIO register bank and the twi_video SDA/SCL pads; it produces the twi_video SDA/SCL port pair of the top-level system.
- Accepts one command per valid/ready handshake and emits START, device address + W, register address, data, STOP.
- Reports completion and ACK/NACK status.

---
 rtl/twi_pkg.sv | 14 +
 rtl/twi_tick_gen.sv | 28 ++
 rtl/twi_reg_writer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/twi_pkg.sv
// Shared TWI master types and frame constants.
package twi_pkg;

  typedef enum logic [2:0] {IDLE, START, BIT, STOP, DONE} twi_state_t;

  localparam int unsigned BITS_PER_BYTE = 9;
  localparam int unsigned BYTES_PER_WR  = 3;
  localparam int unsigned START_Q       = 2;
  localparam int unsigned BIT_Q         = 4;
  localparam int unsigned STOP_Q        = 3;
  localparam logic        TWI_ACK       = 1'b0;
  localparam logic        TWI_NACK      = 1'b1;

endpackage

// File: rtl/twi_tick_gen.sv
// SCL quarter-period tick: counts 0..CLK_DIV-1, one-cycle tick on wrap.
module twi_tick_gen #(
  parameter int unsigned CLK_DIV = 250
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tick
);

  localparam int unsigned CW = $clog2(CLK_DIV);

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == CW'(CLK_DIV - 1));
  assign o_tick = i_enable && w_wrap;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clear) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/twi_reg_writer.sv
// TWI master issuing single-register writes: START, addr+W, reg, data, STOP.
module twi_reg_writer
  import twi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 250
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_cmd_valid,
  output logic       o_cmd_ready,
  input  logic [6:0] i_cmd_dev_addr,
  input  logic [7:0] i_cmd_reg_addr,
  input  logic [7:0] i_cmd_data,
  output logic       o_done,
  output logic       o_nack,
  output logic       o_busy,
  input  logic       i_twi_sda,
  output logic       o_twi_sda,
  output logic       o_twi_scl
);

  twi_state_t  r_state;
  logic [1:0]  r_q;
  logic [3:0]  r_bitn;
  logic [1:0]  r_byte;
  logic [23:0] r_shift;
  logic        r_sda, r_scl, r_ready, r_busy, r_done, r_nack;
  logic        r_sda_meta, r_sda_sync;
  logic        w_tick, w_accept, w_ack_slot;

  assign w_accept   = i_cmd_valid && r_ready;
  assign w_ack_slot = (r_bitn == 4'(BITS_PER_BYTE - 1));

  twi_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clear  (w_accept),
    .i_enable (r_state != IDLE),
    .o_tick   (w_tick)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sda_meta <= 1'b1;
      r_sda_sync <= 1'b1;
    end else begin
      r_sda_meta <= i_twi_sda;
      r_sda_sync <= r_sda_meta;
    end
  end

  // Bus levels are registered one edge ahead: each tick loads the next quarter's SCL/SDA.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_q     <= '0;
      r_bitn  <= '0;
      r_byte  <= '0;
      r_shift <= '0;
      r_sda   <= 1'b1;
      r_scl   <= 1'b1;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_nack  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          r_state <= IDLE;
          if (w_accept) begin
            r_shift <= {i_cmd_dev_addr, 1'b0, i_cmd_reg_addr, i_cmd_data};
            r_nack  <= 1'b0;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= START;
            r_q     <= '0;
            r_scl   <= 1'b1;
            r_sda   <= 1'b1;
          end
        end
        START: if (w_tick) begin
          if (r_q == 2'(START_Q - 1)) begin
            r_state <= BIT;
            r_q     <= '0;
            r_bitn  <= '0;
            r_byte  <= '0;
            r_scl   <= 1'b0;
            r_sda   <= r_shift[23];
          end else begin
            r_q   <= r_q + 1'b1;
            r_sda <= 1'b0;
          end
        end
        BIT: if (w_tick) begin
          if (r_q == 2'(BIT_Q - 1)) begin
            r_q   <= '0;
            r_scl <= 1'b0;
            if (w_ack_slot) begin
              if (r_nack || r_byte == 2'(BYTES_PER_WR - 1)) begin
                r_state <= STOP;
                r_sda   <= 1'b0;
              end else begin
                r_byte <= r_byte + 1'b1;
                r_bitn <= '0;
                r_sda  <= r_shift[23];
              end
            end else begin
              r_shift <= r_shift << 1;
              r_bitn  <= r_bitn + 1'b1;
              r_sda   <= (r_bitn == 4'(BITS_PER_BYTE - 2)) ? 1'b1 : r_shift[22];
            end
          end else begin
            r_q <= r_q + 1'b1;
            if (r_q == 2'd1) r_scl <= 1'b1;
            if (r_q == 2'd2 && w_ack_slot && r_sda_sync != TWI_ACK) r_nack <= TWI_NACK;
          end
        end
        STOP: if (w_tick) begin
          if (r_q == 2'(STOP_Q - 1)) begin
            r_state <= DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
          end else begin
            r_q <= r_q + 1'b1;
            if (r_q == 2'd0) r_scl <= 1'b1;
            else             r_sda <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_cmd_ready = r_ready;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_nack      = r_nack;
  assign o_twi_sda   = r_sda;
  assign o_twi_scl   = r_scl;

endmodule
